// File: rtl/pb_write_arb_pkg.sv
// Shared raytracer pixel-buffer types and constants.
// Purely declarative: no logic, no latency, no flow control.
package pb_write_arb_pkg;

    localparam int PB_ID_W    = 19;
    localparam int PB_COLOR_W = 24;

    localparam logic [PB_COLOR_W-1:0] COLOR_WHITE = 24'hFFFFFF;
    localparam logic [PB_COLOR_W-1:0] COLOR_BLACK = 24'h000000;

    typedef struct packed {
        logic                  valid;
        logic [PB_ID_W-1:0]    pixelID;
        logic [PB_COLOR_W-1:0] color;
    } pixel_buffer_entry_t;

endpackage

// File: rtl/pb_write_arb_rr_arb.sv
// Round-robin grant search from ptr, wrapping; returns the pointer to register next.
// Combinational, zero latency; adv=0 freezes the pointer so a stalled consumer loses no turn.
module rr_arb #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr_nxt
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        sum   = '0;
        idx   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract is enough for the wrap
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (adv && found) begin
            ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/pb_write_arb.sv
// Round-robin merge of NUM_CH pixel streams into one pixel-buffer write port; optional stats via PB_WRITE_ARB_STATS_EN.
// One-cycle latency through a single output register; pb_full holds the entry and stalls every channel.
module pb_write_arb
    import pb_write_arb_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int ID_W    = PB_ID_W,
    parameter int COLOR_W = PB_COLOR_W,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*ID_W-1:0]      ch_pixelID,
    input  logic [NUM_CH*COLOR_W-1:0]   ch_color,
    output logic [NUM_CH-1:0]           ch_stall,
    input  logic                        pb_full,
    output logic                        pb_we,
    output logic [ID_W-1:0]             pb_pixelID,
    output logic [COLOR_W-1:0]          pb_color
`ifdef PB_WRITE_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [NUM_CH*CNT_W-1:0]     stat_xfer,
    output logic [NUM_CH*CNT_W-1:0]     stat_stall
`endif
);

    localparam int PTR_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8 || CNT_W < 1) begin : g_bad_param
        $error("pb_write_arb: NUM_CH must be 2..8 and CNT_W >= 1");
    end

    // Same layout as pixel_buffer_entry_t, sized by this instance's widths.
    typedef struct packed {
        logic               out_v;
        logic [ID_W-1:0]    pixelID;
        logic [COLOR_W-1:0] color;
    } out_entry_t;

    out_entry_t         out_q, out_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_CH-1:0]  grant;
    logic               load_en;
    logic [ID_W-1:0]    sel_id;
    logic [COLOR_W-1:0] sel_color;

    rr_arb #(.N(NUM_CH)) u_rr_arb (
        .req     (ch_valid),
        .ptr     (rr_ptr_q),
        .adv     (load_en),
        .grant   (grant),
        .ptr_nxt (ptr_nxt)
    );

    always_comb begin
        load_en    = !out_q.out_v || !pb_full;
        pb_we      = out_q.out_v && !pb_full;
        pb_pixelID = out_q.pixelID;
        pb_color   = out_q.color;
        // rst gate keeps every channel stalled while the register is held in reset
        ch_stall   = ~(grant & {NUM_CH{load_en && rst}});
    end

    always_comb begin
        sel_id    = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_id    = sel_id    | ch_pixelID[i*ID_W +: ID_W];
                sel_color = sel_color | ch_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        out_d    = out_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            out_d.out_v = |grant;
            if (|grant) begin
                out_d.pixelID = sel_id;
                out_d.color   = sel_color;
            end
            rr_ptr_d = ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            out_q    <= out_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef PB_WRITE_ARB_STATS_EN
    logic [CNT_W-1:0] xfer_q  [NUM_CH];
    logic [CNT_W-1:0] xfer_d  [NUM_CH];
    logic [CNT_W-1:0] stall_q [NUM_CH];
    logic [CNT_W-1:0] stall_d [NUM_CH];

    always_comb begin
        stat_xfer  = '0;
        stat_stall = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            xfer_d[i]  = xfer_q[i];
            stall_d[i] = stall_q[i];
            if (stat_clr) begin
                xfer_d[i]  = '0;
                stall_d[i] = '0;
            end else begin
                if (ch_valid[i] && !ch_stall[i] && !(&xfer_q[i])) begin
                    xfer_d[i] = xfer_q[i] + 1'b1;
                end
                if (ch_valid[i] && ch_stall[i] && !(&stall_q[i])) begin
                    stall_d[i] = stall_q[i] + 1'b1;
                end
            end
            stat_xfer[i*CNT_W +: CNT_W]  = xfer_q[i];
            stat_stall[i*CNT_W +: CNT_W] = stall_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                xfer_q[i]  <= '0;
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                xfer_q[i]  <= xfer_d[i];
                stall_q[i] <= stall_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pb_write_arb.sv
// Bench for pb_write_arb: per-cycle vector table with a write-order scoreboard,
// then hand sequences for reset mid-operation and the optional statistics counters.
module tb_pb_write_arb;
    import pb_write_arb_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int ID_W    = 19;
    localparam int COLOR_W = 24;
    localparam int CNT_W   = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH*ID_W-1:0]    ch_pixelID;
    logic [NUM_CH*COLOR_W-1:0] ch_color;
    logic [NUM_CH-1:0]         ch_stall;
    logic                      pb_full;
    logic                      pb_we;
    logic [ID_W-1:0]           pb_pixelID;
    logic [COLOR_W-1:0]        pb_color;
`ifdef PB_WRITE_ARB_STATS_EN
    logic                      stat_clr;
    logic [NUM_CH*CNT_W-1:0]   stat_xfer;
    logic [NUM_CH*CNT_W-1:0]   stat_stall;
`endif

    pb_write_arb #(
        .NUM_CH(NUM_CH), .ID_W(ID_W), .COLOR_W(COLOR_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_pixelID (ch_pixelID),
        .ch_color   (ch_color),
        .ch_stall   (ch_stall),
        .pb_full    (pb_full),
        .pb_we      (pb_we),
        .pb_pixelID (pb_pixelID),
        .pb_color   (pb_color)
`ifdef PB_WRITE_ARB_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_xfer  (stat_xfer),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] valid;
        logic       full;
        logic [2:0] exp_stall;
        logic       exp_we;
    } vec_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [COLOR_W-1:0] col;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   seq[NUM_CH];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [ID_W-1:0] id_of(int ch, int s);
        return ID_W'((ch + 1) * 1000 + s);
    endfunction

    function automatic logic [COLOR_W-1:0] col_of(int ch, int s);
        if (ch == 0) return COLOR_WHITE;
        if (ch == 1) return COLOR_BLACK;
        return 24'h5A0000 + COLOR_W'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ch(input logic [2:0] v);
        ch_valid = v;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_pixelID[i*ID_W +: ID_W]       = id_of(i, seq[i]);
            ch_color[i*COLOR_W +: COLOR_W]   = col_of(i, seq[i]);
        end
    endtask

    task automatic add_vec(input logic [2:0] v, input logic f, input logic [2:0] s, input logic w);
        vec_t t;
        t.valid = v; t.full = f; t.exp_stall = s; t.exp_we = w;
        vecs.push_back(t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;
        for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
        rst      = 1'b0;
        pb_full  = 1'b0;
`ifdef PB_WRITE_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        drive_ch(3'b111);

        // valid, full, expected stall {ch2,ch1,ch0}, expected pb_we
        add_vec(3'b111, 0, 3'b110, 0);  // all valid: ch0,ch1,ch2 rotation
        add_vec(3'b111, 0, 3'b101, 1);
        add_vec(3'b111, 0, 3'b011, 1);
        add_vec(3'b111, 0, 3'b110, 1);  // pointer wrapped to ch0
        add_vec(3'b111, 0, 3'b101, 1);
        add_vec(3'b111, 0, 3'b011, 1);
        add_vec(3'b000, 0, 3'b111, 1);
        add_vec(3'b000, 0, 3'b111, 0);
        add_vec(3'b100, 0, 3'b011, 0);  // lone ch2, back-to-back
        add_vec(3'b100, 0, 3'b011, 1);
        add_vec(3'b100, 0, 3'b011, 1);
        add_vec(3'b000, 0, 3'b111, 1);
        add_vec(3'b000, 0, 3'b111, 0);
        add_vec(3'b001, 0, 3'b110, 0);  // ch0 loads, then 4 full cycles
        add_vec(3'b010, 1, 3'b111, 0);
        add_vec(3'b010, 1, 3'b111, 0);
        add_vec(3'b010, 1, 3'b111, 0);
        add_vec(3'b010, 1, 3'b111, 0);
        add_vec(3'b010, 0, 3'b101, 1);  // held entry written, ch1 loaded same cycle
        add_vec(3'b000, 0, 3'b111, 1);
        add_vec(3'b001, 1, 3'b110, 0);  // empty register fills despite full
        add_vec(3'b000, 1, 3'b111, 0);
        add_vec(3'b000, 0, 3'b111, 1);
        add_vec(3'b011, 0, 3'b101, 0);  // pointer at 1 picks ch1 first
        add_vec(3'b011, 0, 3'b110, 1);
        add_vec(3'b000, 0, 3'b111, 1);
        add_vec(3'b000, 0, 3'b111, 0);

        #2;
        chk("reset pb_we", pb_we, 0);
        chk("reset pb_pixelID", pb_pixelID, 0);
        chk("reset pb_color", pb_color, 0);
        chk("reset ch_stall", ch_stall, 3'b111);

        ch_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < vecs.size(); r++) begin
            drive_ch(vecs[r].valid);
            pb_full = vecs[r].full;
            @(negedge clk);
            chk($sformatf("row%0d pb_we", r), pb_we, vecs[r].exp_we);
            chk($sformatf("row%0d ch_stall", r), ch_stall, vecs[r].exp_stall);
            if (vecs[r].full && sb.size() > 0) begin
                chk($sformatf("row%0d held id", r), pb_pixelID, sb[0].id);
            end
            if (pb_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL row%0d write: got unexpected write id %0h", r, pb_pixelID);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("row%0d pb_pixelID", r), pb_pixelID, e.id);
                    chk($sformatf("row%0d pb_color", r), pb_color, e.col);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (vecs[r].valid[i] && !vecs[r].exp_stall[i]) begin
                    sb.push_back({id_of(i, seq[i]), col_of(i, seq[i])});
                    seq[i]++;
                end
            end
            @(posedge clk); #1;
        end
        chk("scoreboard drained", sb.size(), 0);

        // Reset while an entry is held under pb_full; pointer would sit at ch1 if not reset.
        drive_ch(3'b001);
        pb_full = 1'b0;
        @(posedge clk); #1;
        drive_ch(3'b011);
        pb_full = 1'b1;
        @(negedge clk);
        chk("pre-reset pb_we", pb_we, 0);
        #1 rst = 1'b0;
        #1;
        chk("mid-reset pb_we", pb_we, 0);
        chk("mid-reset ch_stall", ch_stall, 3'b111);
        pb_full = 1'b0;
        #1;
        chk("mid-reset ch_stall no full", ch_stall, 3'b111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post-reset grant ch0", ch_stall, 3'b110);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-reset pb_we", pb_we, 1);
        chk("post-reset pb_pixelID", pb_pixelID, id_of(0, seq[0]));
        seq[0]++;
        drive_ch(3'b000);
        @(posedge clk); #1;
        @(posedge clk); #1;

`ifdef PB_WRITE_ARB_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_ch(3'b010);
            @(posedge clk); #1;
            seq[1]++;
        end
        pb_full = 1'b1;
        drive_ch(3'b010);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        drive_ch(3'b000);
        pb_full = 1'b0;
        @(negedge clk);
        chk("stat_xfer ch1", stat_xfer[1*CNT_W +: CNT_W], 5);
        chk("stat_stall ch1", stat_stall[1*CNT_W +: CNT_W], 3);
        chk("stat_xfer ch0", stat_xfer[0 +: CNT_W], 0);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        chk("stat_xfer ch1 cleared", stat_xfer[1*CNT_W +: CNT_W], 0);
        chk("stat_stall ch1 cleared", stat_stall[1*CNT_W +: CNT_W], 0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
